instr_encoder: RTL and testbench

- Companion to the control-path decoder: packs instruction fields (cond, Op, Funct, Rn, Rd, shift, Rm, immediate) into 32-bit ARMv4 machine words.
- Emits each word with a running word address so the test loader can write instruction memory.
- Sits between the testbench/host field source and the instruction-memory write port.
- Handles data-processing, memory (LDR/STR) and branch classes; data-processing immediates are fitted to the imm8/rot4 form by a multi-cycle rotation search.

---
 rtl/enc_pkg.sv | 52 +++++
 rtl/imm_rot_check.sv | 25 ++
 rtl/instr_encoder.sv | 278 +++++++++++++++++++++++++++
 tb/tb_instr_encoder.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared definitions for the ARMv4 instruction encoder.
//   - instruction class codes carried on op_i
//   - encoder FSM state type
//   - bit offsets of the machine-word fields
//   - helper that packs a data-processing immediate word
package enc_pkg;

    // Instruction classes
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT  = 2'd1,
        EMIT = 2'd2
    } state_e;

    // Machine-word field offsets (LSB positions)
    localparam int unsigned COND_LSB  = 28;
    localparam int unsigned CLASS_LSB = 26;
    localparam int unsigned I_BIT     = 25;
    localparam int unsigned FUNCT_LSB = 20;
    localparam int unsigned RN_LSB    = 16;
    localparam int unsigned RD_LSB    = 12;
    localparam int unsigned ROT_LSB   = 8;
    localparam int unsigned IMM8_LSB  = 0;

    // Data-processing word with an imm8/rot4 operand
    function automatic logic [31:0] dp_imm_word(
        input logic [3:0] cond,
        input logic [4:0] funct,
        input logic [3:0] rn,
        input logic [3:0] rd,
        input logic [3:0] rot,
        input logic [7:0] imm8
    );
        logic [31:0] w;
        w                   = '0;
        w[COND_LSB +: 4]    = cond;
        w[CLASS_LSB +: 2]   = OP_DP;
        w[I_BIT]            = 1'b1;
        w[FUNCT_LSB +: 5]   = funct;
        w[RN_LSB +: 4]      = rn;
        w[RD_LSB +: 4]      = rd;
        w[ROT_LSB +: 4]     = rot;
        w[IMM8_LSB +: 8]    = imm8;
        return w;
    endfunction

endpackage

// File: rtl/imm_rot_check.sv
// Tests whether a 32-bit immediate becomes an 8-bit value after rotating it left by 2*r.
// A hit means the immediate is representable as ROR(imm8, 2*r).
//   imm32_i : immediate under test
//   r_i     : candidate rotation field
//   hit_o   : rotated value fits in 8 bits
//   imm8_o  : low byte of the rotated value
module imm_rot_check (
    input  logic [31:0] imm32_i,
    input  logic [3:0]  r_i,
    output logic        hit_o,
    output logic [7:0]  imm8_o
);

    logic [63:0] dbl;
    logic [31:0] rotated;

    // Upper half of the doubled word shifted left is a rotate-left of the original
    always_comb begin
        dbl     = {imm32_i, imm32_i} << {r_i, 1'b0};
        rotated = dbl[63:32];
        hit_o   = (rotated[31:8] == 24'd0);
        imm8_o  = rotated[7:0];
    end

endmodule

// File: rtl/instr_encoder.sv
// Packs instruction fields into 32-bit ARMv4 machine words and emits each one with a running
// byte address for the instruction-memory loader.
// Optional feature macro: ENC_ROT_PARALLEL_EN -- when defined, all 16 immediate rotations are
// tested in the accept cycle instead of one per cycle in the ROT state.
// Ports:
//   clk_i, rst_ni             : clock, synchronous active-low reset
//   in_valid_i / in_ready_o   : field-set handshake
//   cond_i, op_i, funct_i     : condition, class, Funct field
//   rn_i, rd_i, rm_i          : register fields
//   sh_i, shamt_i             : shift type and amount
//   imm32_i                   : immediate / byte offset / signed branch word offset
//   instr_o, addr_o           : encoded word and its byte address
//   out_valid_o / out_ready_i : output handshake
//   err_o                     : one-cycle pulse when a field set is rejected
module instr_encoder
    import enc_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [3:0]        cond_i,
    input  logic [1:0]        op_i,
    input  logic [5:0]        funct_i,
    input  logic [3:0]        rn_i,
    input  logic [3:0]        rd_i,
    input  logic [3:0]        rm_i,
    input  logic [1:0]        sh_i,
    input  logic [4:0]        shamt_i,
    input  logic [31:0]       imm32_i,
    output logic [31:0]       instr_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              err_o
);

    state_e            state_q, state_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;

    logic              accept;
    logic              is_dp_imm;
    logic              direct_ok;
    logic [31:0]       direct_word;
    logic [11:0]       off12;

    assign accept    = in_valid_i && (state_q == IDLE);
    assign is_dp_imm = (op_i == OP_DP) && funct_i[5];

    // Every class except DP-immediate is built straight from the inputs at accept
    always_comb begin
        direct_ok   = 1'b0;
        direct_word = '0;
        off12       = funct_i[5] ? {shamt_i, sh_i, 1'b0, rm_i} : imm32_i[11:0];
        case (op_i)
            OP_DP: begin
                direct_ok   = 1'b1;
                direct_word = {cond_i, 2'b00, 1'b0, funct_i[4:0], rn_i, rd_i,
                               shamt_i, sh_i, 1'b0, rm_i};
            end
            OP_MEM: begin
                direct_ok   = funct_i[5] || (imm32_i[31:12] == 20'd0);
                direct_word = {cond_i, 2'b01, funct_i, rn_i, rd_i, off12};
            end
            OP_BR: begin
                // Offset must sign-extend from 24 bits
                direct_ok   = (imm32_i[31:23] == 9'h000) || (imm32_i[31:23] == 9'h1FF);
                direct_word = {cond_i, 3'b101, funct_i[4], imm32_i[23:0]};
            end
            OP_ILL: begin
                direct_ok   = 1'b0;
            end
            default: begin
                direct_ok   = 1'b0;
            end
        endcase
    end

`ifdef ENC_ROT_PARALLEL_EN
    logic [15:0] par_hit;
    logic [7:0]  par_imm8 [16];
    logic        par_any;
    logic [3:0]  par_r;
    logic [7:0]  par_sel;

    for (genvar g = 0; g < 16; g++) begin : g_rot
        imm_rot_check u_rot_check (
            .imm32_i (imm32_i),
            .r_i     (4'(g)),
            .hit_o   (par_hit[g]),
            .imm8_o  (par_imm8[g])
        );
    end

    // Descending scan so the lowest rotation that fits wins
    always_comb begin
        par_any = 1'b0;
        par_r   = '0;
        par_sel = '0;
        for (int i = 15; i >= 0; i--) begin
            if (par_hit[i]) begin
                par_any = 1'b1;
                par_r   = 4'(i);
                par_sel = par_imm8[i];
            end
        end
    end
`else
    // Fields needed by the rotation search, captured at accept
    logic [3:0]  r_q, r_d;
    logic [3:0]  cond_q, cond_d;
    logic [4:0]  funct_q, funct_d;
    logic [3:0]  rn_q, rn_d;
    logic [3:0]  rd_q, rd_d;
    logic [31:0] imm_q, imm_d;
    logic        seq_hit;
    logic [7:0]  seq_imm8;

    imm_rot_check u_rot_check (
        .imm32_i (imm_q),
        .r_i     (r_q),
        .hit_o   (seq_hit),
        .imm8_o  (seq_imm8)
    );

    always_comb begin
        r_d     = r_q;
        cond_d  = cond_q;
        funct_d = funct_q;
        rn_d    = rn_q;
        rd_d    = rd_q;
        imm_d   = imm_q;
        if (accept) begin
            r_d     = '0;
            cond_d  = cond_i;
            funct_d = funct_i[4:0];
            rn_d    = rn_i;
            rd_d    = rd_i;
            imm_d   = imm32_i;
        end else if ((state_q == ROT) && !seq_hit) begin
            r_d = r_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_q     <= '0;
            cond_q  <= '0;
            funct_q <= '0;
            rn_q    <= '0;
            rd_q    <= '0;
            imm_q   <= '0;
        end else begin
            r_q     <= r_d;
            cond_q  <= cond_d;
            funct_q <= funct_d;
            rn_q    <= rn_d;
            rd_q    <= rd_d;
            imm_q   <= imm_d;
        end
    end
`endif

    // FSM: state register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_dp_imm) begin
`ifdef ENC_ROT_PARALLEL_EN
                        state_d = par_any ? EMIT : IDLE;
`else
                        state_d = ROT;
`endif
                    end else if (direct_ok) begin
                        state_d = EMIT;
                    end
                end
            end
            ROT: begin
`ifdef ENC_ROT_PARALLEL_EN
                state_d = IDLE;
`else
                if (seq_hit) begin
                    state_d = EMIT;
                end else if (r_q == 4'd15) begin
                    state_d = IDLE;
                end
`endif
            end
            EMIT: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready_o  = (state_q == IDLE);
        out_valid_o = (state_q == EMIT);
        instr_o     = instr_q;
        addr_o      = addr_q;
        err_o       = err_q;
    end

    // Word, address and error pulse
    always_comb begin
        instr_d = instr_q;
        addr_d  = addr_q;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_dp_imm) begin
`ifdef ENC_ROT_PARALLEL_EN
                        if (par_any) begin
                            instr_d = dp_imm_word(cond_i, funct_i[4:0], rn_i, rd_i,
                                                  par_r, par_sel);
                        end else begin
                            err_d = 1'b1;
                        end
`endif
                    end else if (direct_ok) begin
                        instr_d = direct_word;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ROT: begin
`ifndef ENC_ROT_PARALLEL_EN
                if (seq_hit) begin
                    instr_d = dp_imm_word(cond_q, funct_q, rn_q, rd_q, r_q, seq_imm8);
                end else if (r_q == 4'd15) begin
                    err_d = 1'b1;
                end
`endif
            end
            EMIT: begin
                if (out_ready_i) begin
                    addr_d = addr_q + ADDR_W'(4);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            instr_q <= '0;
            addr_q  <= BASE_ADDR;
            err_q   <= 1'b0;
        end else begin
            instr_q <= instr_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rn, rd, rm;
    logic [1:0]  sh;
    logic [4:0]  shamt;
    logic [31:0] imm32;
    logic [31:0] instr;
    logic [31:0] addr;
    logic        out_valid;
    logic        out_ready;
    logic        err;

    always #5 clk = ~clk;

    instr_encoder #(
        .ADDR_W    (32),
        .BASE_ADDR (32'h0)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .cond_i      (cond),
        .op_i        (op),
        .funct_i     (funct),
        .rn_i        (rn),
        .rd_i        (rd),
        .rm_i        (rm),
        .sh_i        (sh),
        .shamt_i     (shamt),
        .imm32_i     (imm32),
        .instr_o     (instr),
        .addr_o      (addr),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .err_o       (err)
    );

    typedef struct packed {
        logic [3:0]  cond;
        logic [1:0]  op;
        logic [5:0]  funct;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [3:0]  rm;
        logic [1:0]  sh;
        logic [4:0]  shamt;
        logic [31:0] imm;
    } fields_t;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected per-cycle outputs, maintained by the stimulus thread
    logic        chk_en    = 1'b0;
    logic        chk_instr = 1'b0;
    logic        exp_ir    = 1'b1;
    logic        exp_ov    = 1'b0;
    logic        exp_err   = 1'b0;
    logic [31:0] exp_instr = '0;
    logic [31:0] exp_addr  = '0;
    logic [31:0] model_addr = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Compare process: mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", 64'(in_ready), 64'(exp_ir));
            chk("out_valid", 64'(out_valid), 64'(exp_ov));
            chk("err", 64'(err), 64'(exp_err));
            chk("addr", 64'(addr), 64'(exp_addr));
            if (exp_ov || chk_instr) begin
                chk("instr", 64'(instr), 64'(exp_instr));
            end
        end
    end

    function automatic logic [31:0] rol32(input logic [31:0] x, input int s);
        if (s == 0) return x;
        return (x << s) | (x >> (32 - s));
    endfunction

    function automatic logic [31:0] ror32(input logic [31:0] x, input int s);
        if (s == 0) return x;
        return (x >> s) | (x << (32 - s));
    endfunction

    // Reference: outcome, word and cycles from accept to out_valid/err
    function automatic void model(input fields_t f, output bit ok, output logic [31:0] w,
                                  output int lat);
        logic [31:0] v;
        ok  = 1'b1;
        w   = '0;
        lat = 1;
        case (f.op)
            2'b00: begin
                if (f.funct[5]) begin
                    ok  = 1'b0;
                    lat = 17;
                    for (int r = 0; r < 16; r++) begin
                        v = rol32(f.imm, 2 * r);
                        if (!ok && v < 32'd256) begin
                            ok  = 1'b1;
                            lat = 2 + r;
                            w   = {f.cond, 2'b00, 1'b1, f.funct[4:0], f.rn, f.rd, 4'(r), v[7:0]};
                        end
                    end
`ifdef ENC_ROT_PARALLEL_EN
                    lat = 1;
`endif
                end else begin
                    w = {f.cond, 2'b00, 1'b0, f.funct[4:0], f.rn, f.rd, f.shamt, f.sh, 1'b0, f.rm};
                end
            end
            2'b01: begin
                ok = f.funct[5] || (f.imm < 32'h1000);
                if (f.funct[5]) begin
                    w = {f.cond, 2'b01, f.funct, f.rn, f.rd, f.shamt, f.sh, 1'b0, f.rm};
                end else begin
                    w = {f.cond, 2'b01, f.funct, f.rn, f.rd, f.imm[11:0]};
                end
            end
            2'b10: begin
                ok = ($signed(f.imm) >= -32'sd8388608) && ($signed(f.imm) <= 32'sd8388607);
                w  = {f.cond, 3'b101, f.funct[4], f.imm[23:0]};
            end
            default: ok = 1'b0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input logic ir, input logic ov, input logic e);
        exp_ir  = ir;
        exp_ov  = ov;
        exp_err = e;
    endtask

    task automatic drive(input fields_t f);
        cond  = f.cond;
        op    = f.op;
        funct = f.funct;
        rn    = f.rn;
        rd    = f.rd;
        rm    = f.rm;
        sh    = f.sh;
        shamt = f.shamt;
        imm32 = f.imm;
    endtask

    task automatic garbage();
        fields_t g;
        g = fields_t'({$urandom, $urandom});
        drive(g);
    endtask

    // One transaction; the DUT is expected idle on entry and is left idle on exit
    task automatic send(input fields_t f, input int hold);
        bit          ok;
        logic [31:0] w;
        int          lat;
        model(f, ok, w, lat);
        drive(f);
        in_valid  = 1'b1;
        out_ready = 1'($urandom);
        set_exp(1'b1, 1'b0, 1'b0);
        step();
        for (int c = 1; c < lat; c++) begin
            garbage();
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            set_exp(1'b0, 1'b0, 1'b0);
            step();
        end
        garbage();
        in_valid = 1'b0;
        if (!ok) begin
            out_ready = 1'($urandom);
            set_exp(1'b1, 1'b0, 1'b1);
            step();
            out_ready = 1'b0;
            set_exp(1'b1, 1'b0, 1'b0);
        end else begin
            exp_instr = w;
            for (int c = 0; c < hold; c++) begin
                out_ready = 1'b0;
                in_valid  = 1'($urandom);
                set_exp(1'b0, 1'b1, 1'b0);
                step();
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            set_exp(1'b0, 1'b1, 1'b0);
            step();
            model_addr = model_addr + 32'd4;
            exp_addr   = model_addr;
            out_ready  = 1'b0;
            set_exp(1'b1, 1'b0, 1'b0);
        end
    endtask

    // Pins the reference model to hand-computed values
    task automatic pin(input string name, input fields_t f, input bit eok,
                       input logic [31:0] eword, input int elat);
        bit          ok;
        logic [31:0] w;
        int          lat;
        model(f, ok, w, lat);
        chk({name, "_ok"}, 64'(ok), 64'(eok));
        if (eok) chk({name, "_word"}, 64'(w), 64'(eword));
`ifndef ENC_ROT_PARALLEL_EN
        chk({name, "_lat"}, 64'(lat), 64'(elat));
`endif
    endtask

    function automatic fields_t mk(input logic [1:0] o, input logic [5:0] fn, input logic [3:0] n,
                                   input logic [3:0] d, input logic [31:0] im);
        fields_t f;
        f       = '0;
        f.cond  = 4'hE;
        f.op    = o;
        f.funct = fn;
        f.rn    = n;
        f.rd    = d;
        f.imm   = im;
        return f;
    endfunction

    fields_t f_add_ff, f_add_rot, f_bad, f_ldr, f_b, f_ill, f_mem_big;

    initial begin
        f_add_ff  = mk(2'b00, 6'b101000, 4'd2, 4'd1, 32'h0000_00FF);
        f_add_rot = mk(2'b00, 6'b101000, 4'd2, 4'd1, 32'hFF00_0000);
        f_bad     = mk(2'b00, 6'b101000, 4'd2, 4'd1, 32'h0000_0101);
        f_ldr     = mk(2'b01, 6'b011001, 4'd0, 4'd3, 32'h0000_0008);
        f_b       = mk(2'b10, 6'b000000, 4'd0, 4'd0, 32'hFFFF_FFFE);
        f_ill     = mk(2'b11, 6'b000000, 4'd1, 4'd1, 32'h0);
        f_mem_big = mk(2'b01, 6'b011001, 4'd0, 4'd3, 32'h0000_1000);

        pin("m_add_ff", f_add_ff, 1'b1, 32'hE282_10FF, 2);
        pin("m_add_rot", f_add_rot, 1'b1, 32'hE282_14FF, 6);
        pin("m_bad", f_bad, 1'b0, 32'h0, 17);
        pin("m_ldr", f_ldr, 1'b1, 32'hE590_3008, 1);
        pin("m_b", f_b, 1'b1, 32'hEAFF_FFFE, 1);
        pin("m_mem_big", f_mem_big, 1'b0, 32'h0, 1);

        // Power-on reset
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        garbage();
        step();
        step();
        chk_en    = 1'b1;
        chk_instr = 1'b1;
        exp_instr = '0;
        set_exp(1'b1, 1'b0, 1'b0);
        rst_n     = 1'b1;
        step();
        chk_instr = 1'b0;

        // Directed cases
        send(f_add_ff, 0);
        send(f_add_rot, 5);
        send(f_bad, 0);
        send(f_ill, 0);
        send(f_mem_big, 1);

        // Reset while the rotation search is running
        drive(f_bad);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        set_exp(1'b0, 1'b0, 1'b0);
        step();
        step();
        rst_n  = 1'b0;
        chk_en = 1'b0;
        step();
        rst_n      = 1'b1;
        chk_en     = 1'b1;
        chk_instr  = 1'b1;
        exp_instr  = '0;
        model_addr = '0;
        exp_addr   = '0;
        set_exp(1'b1, 1'b0, 1'b0);
        step();
        chk_instr = 1'b0;

        send(f_ldr, 0);
        chk("b_model_addr", 64'(model_addr), 64'h4);
        send(f_b, 2);

        // Randomized field sets
        for (int t = 0; t < 80; t++) begin
            fields_t f;
            logic [31:0] x;
            f = fields_t'({$urandom, $urandom});
            x = $urandom;
            case (f.op)
                2'b00: begin
                    if ($urandom_range(0, 9) < 6) f.imm = ror32({24'd0, x[7:0]}, 2 * int'(x[11:8]));
                    else if ($urandom_range(0, 1) == 0) f.imm = x;
                    else f.imm = {24'd0, x[7:0]};
                end
                2'b01: begin
                    if ($urandom_range(0, 9) < 8) f.imm = {20'd0, x[11:0]};
                end
                2'b10: begin
                    if ($urandom_range(0, 9) < 8) f.imm = {{8{x[23]}}, x[23:0]};
                end
                default: ;
            endcase
            send(f, $urandom_range(0, 2));
        end

        step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
